cpu_bus_master: RTL and testbench



---
 rtl/cpu_bus_master.sv | 157 +++++++++++++++
 tb/tb_cpu_bus_master.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_master.sv
// 6809-style bus initiator: E/Q quadrature from CLKX4, one read/write/vector
// cycle per E period from a req/ack handshake, MRDY stretch with timeout.
// Ports: CLKX4/nRESET clock and sync reset; req* request payload; ack/done/
// err/rdata handshake results; E/Q/ADDR/RnW/BA/BS/DATA bus; MRDY stretch in.
module cpu_bus_master #(
  parameter int          MAX_STRETCH = 15,
  parameter logic [15:0] IDLE_ADDR   = 16'hFFFF
) (
  input  logic        CLKX4,
  input  logic        nRESET,
  input  logic        req,
  input  logic        req_rnw,
  input  logic        req_vec,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        E,
  output logic        Q,
  output logic [15:0] ADDR,
  output logic        RnW,
  output logic        BA,
  output logic        BS,
  input  logic        MRDY,
  inout  wire  [7:0]  DATA
);

  localparam logic [1:0] P0 = 2'd0;
  localparam logic [1:0] P1 = 2'd1;
  localparam logic [1:0] P2 = 2'd2;
  localparam logic [1:0] P3 = 2'd3;
  localparam logic [7:0] MAXS = 8'(MAX_STRETCH);

  logic [1:0]  phase_q, phase_d;
  logic [7:0]  stretch_q, stretch_d;
  logic        e_q, e_d;
  logic        q_q, q_d;
  logic [15:0] addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic        bs_q, bs_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        act_q, act_d;
  logic        oe_q, oe_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        adv;
  logic        tmo;

  always_comb begin
    phase_d   = phase_q;
    stretch_d = stretch_q;
    adv       = 1'b0;
    tmo       = 1'b0;
    unique case (phase_q)
      P0: phase_d = P1;
      P1: phase_d = P2;
      P2: phase_d = P3;
      default: begin
        if (MRDY) begin
          adv = 1'b1;
        end else if (stretch_q == MAXS) begin
          adv = 1'b1;
          tmo = 1'b1;
        end else begin
          stretch_d = stretch_q + 8'd1;
        end
      end
    endcase
    if (adv) begin
      phase_d   = P0;
      stretch_d = 8'd0;
    end

    // Leaving P3 is the capture edge: close the old cycle, open the new.
    addr_d  = addr_q;
    rnw_d   = rnw_q;
    bs_d    = bs_q;
    wdata_d = wdata_q;
    act_d   = act_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (adv) begin
      done_d = act_q;
      err_d  = act_q & tmo;
      if (act_q && rnw_q) rdata_d = DATA;
      act_d = req;
      ack_d = req;
      if (req) begin
        addr_d  = req_addr;
        rnw_d   = req_rnw | req_vec;
        bs_d    = req_vec;
        wdata_d = req_wdata;
      end else begin
        addr_d = IDLE_ADDR;
        rnw_d  = 1'b1;
        bs_d   = 1'b0;
      end
    end

    e_d  = phase_d[1];
    q_d  = phase_d[1] ^ phase_d[0];
    oe_d = act_d & ~rnw_d & (phase_d != P0);
  end

  always_ff @(posedge CLKX4) begin
    if (!nRESET) begin
      phase_q   <= P0;
      stretch_q <= 8'd0;
      e_q       <= 1'b0;
      q_q       <= 1'b0;
      addr_q    <= IDLE_ADDR;
      rnw_q     <= 1'b1;
      bs_q      <= 1'b0;
      wdata_q   <= 8'h00;
      act_q     <= 1'b0;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      phase_q   <= phase_d;
      stretch_q <= stretch_d;
      e_q       <= e_d;
      q_q       <= q_d;
      addr_q    <= addr_d;
      rnw_q     <= rnw_d;
      bs_q      <= bs_d;
      wdata_q   <= wdata_d;
      act_q     <= act_d;
      oe_q      <= oe_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign DATA  = oe_q ? wdata_q : 8'bz;
  assign E     = e_q;
  assign Q     = q_q;
  assign ADDR  = addr_q;
  assign RnW   = rnw_q;
  assign BA    = 1'b0;
  assign BS    = bs_q;
  assign ack   = ack_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: read, write, stretch, timeout,
// no-stretch build, back-to-back, vector, idle and mid-cycle reset.
module tb_cpu_bus_master;

  logic        CLKX4 = 1'b0;
  logic        nRESET = 1'b0;
  logic        req = 1'b0;
  logic        req0 = 1'b0;
  logic        req_rnw = 1'b1;
  logic        req_vec = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        MRDY = 1'b1;
  logic        mrdy0 = 1'b0;
  logic        ack, done, err, E, Q, RnW, BA, BS;
  logic [7:0]  rdata;
  logic [15:0] ADDR;
  wire  [7:0]  DATA;
  logic        ack0, done0, err0, e0, q0, rnw0, ba0, bs0;
  logic [7:0]  rdata0;
  logic [15:0] addr0;
  wire  [7:0]  data0;
  logic        resp_on = 1'b1;
  logic [7:0]  resp_val = 8'h00;
  logic        probe_on = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // Responder drives read data while E is high; the probe drives a
  // marker in P0 so an undriven-by-DUT bus reads back as 8'hA5.
  assign DATA = (resp_on && E && RnW) ? resp_val :
                (probe_on && !E && !Q) ? 8'hA5 : 8'bz;
  assign data0 = (e0 && rnw0) ? 8'h3C : 8'bz;

  always #5 CLKX4 = ~CLKX4;

  cpu_bus_master #(.MAX_STRETCH(15), .IDLE_ADDR(16'hFFFF)) dut (
    .CLKX4(CLKX4), .nRESET(nRESET), .req(req), .req_rnw(req_rnw),
    .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .done(done), .err(err), .rdata(rdata), .E(E), .Q(Q),
    .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS), .MRDY(MRDY), .DATA(DATA)
  );

  cpu_bus_master #(.MAX_STRETCH(0), .IDLE_ADDR(16'hFFFF)) dut0 (
    .CLKX4(CLKX4), .nRESET(nRESET), .req(req0), .req_rnw(req_rnw),
    .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack0), .done(done0), .err(err0), .rdata(rdata0), .E(e0),
    .Q(q0), .ADDR(addr0), .RnW(rnw0), .BA(ba0), .BS(bs0),
    .MRDY(mrdy0), .DATA(data0)
  );

  task automatic tick;
    @(negedge CLKX4);
  endtask

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ack) begin
        n = i;
        break;
      end
    end
  endtask

  // Counts E-high samples until done; got=0 if done never came.
  task automatic wait_done(output int eh, output bit got);
    eh = 0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
      if (E) eh++;
    end
  endtask

  task automatic test_reset;
    nRESET = 1'b0;
    probe_on = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({E, Q, RnW, BA, BS} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_bus got %b exp 00100", {E, Q, RnW, BA, BS});
    end
    checks++;
    if (ADDR !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_addr got %h exp ffff", ADDR);
    end
    checks++;
    if ({ack, done, err, rdata} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hs got %b/%b/%b/%h exp 0/0/0/00",
               ack, done, err, rdata);
    end
    checks++;
    if (DATA !== 8'hA5) begin
      errors++;
      $display("FAIL reset_data_hiz got %h exp a5", DATA);
    end
    probe_on = 1'b0;
    nRESET = 1'b1;
  endtask

  task automatic test_read;
    int n, eh;
    bit got;
    req_addr = 16'hFE10;
    req_rnw = 1'b1;
    resp_val = 8'h5A;
    req = 1'b1;
    wait_ack(n);
    checks++;
    if (n < 0) begin
      errors++;
      $display("FAIL read_ack got timeout exp ack");
    end
    checks++;
    if ({ADDR, RnW, BA, BS, E, Q} !== {16'hFE10, 5'b10000}) begin
      errors++;
      $display("FAIL read_p0 got %h %b exp fe10 10000",
               ADDR, {RnW, BA, BS, E, Q});
    end
    req = 1'b0;
    wait_done(eh, got);
    checks++;
    if (!got || eh != 2) begin
      errors++;
      $display("FAIL read_e_high got %0d done=%0d exp 2 done=1", eh, got);
    end
    checks++;
    if ({rdata, err} !== {8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL read_rdata got %h err=%b exp 5a err=0", rdata, err);
    end
  endtask

  task automatic test_write;
    int n, bad;
    bit got;
    req_addr = 16'hFE11;
    req_wdata = 8'h13;
    req_rnw = 1'b0;
    probe_on = 1'b1;
    req = 1'b1;
    wait_ack(n);
    req = 1'b0;
    bad = 0;
    if (DATA !== 8'hA5) bad++;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
      if ((E || Q) && DATA !== 8'h13) bad++;
      if (!E && !Q && DATA !== 8'hA5) bad++;
    end
    if (DATA !== 8'hA5) bad++;
    checks++;
    if (n < 0 || !got || bad != 0) begin
      errors++;
      $display("FAIL write_data got n=%0d done=%0d bad=%0d exp bad=0",
               n, got, bad);
    end
    checks++;
    if ({rdata, err} !== {8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL write_rdata got %h err=%b exp 5a err=0", rdata, err);
    end
    probe_on = 1'b0;
    req_rnw = 1'b1;
  endtask

  task automatic test_stretch;
    int n, eh, held, moved;
    bit got;
    req_addr = 16'hFE12;
    resp_val = 8'hC3;
    req = 1'b1;
    wait_ack(n);
    req = 1'b0;
    eh = 0;
    held = 0;
    moved = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        got = 1;
        break;
      end
      if (E) eh++;
      if (ADDR !== 16'hFE12) moved++;
      if (E && !Q && held < 3) begin
        MRDY = 1'b0;
        held++;
      end else begin
        MRDY = 1'b1;
      end
    end
    MRDY = 1'b1;
    checks++;
    if (n < 0 || !got || eh != 5) begin
      errors++;
      $display("FAIL stretch_e_high got %0d exp 5", eh);
    end
    checks++;
    if (moved != 0 || err !== 1'b0 || rdata !== 8'hC3) begin
      errors++;
      $display("FAIL stretch_hold got moved=%0d err=%b rd=%h exp 0 0 c3",
               moved, err, rdata);
    end
  endtask

  task automatic test_timeout;
    int n, eh;
    bit got;
    req_addr = 16'hFE13;
    req = 1'b1;
    wait_ack(n);
    req = 1'b0;
    MRDY = 1'b0;
    wait_done(eh, got);
    MRDY = 1'b1;
    checks++;
    if (n < 0 || !got || eh != 17) begin
      errors++;
      $display("FAIL timeout_e_high got %0d exp 17", eh);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got %b exp 1", err);
    end
  endtask

  task automatic test_nostretch;
    int eh;
    bit ok, got;
    req_addr = 16'h2000;
    req0 = 1'b1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ack0) begin
        ok = 1;
        break;
      end
    end
    req0 = 1'b0;
    eh = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done0) begin
        got = 1;
        break;
      end
      if (e0) eh++;
    end
    checks++;
    if (!ok || !got || eh != 2) begin
      errors++;
      $display("FAIL nostretch_e_high got %0d exp 2", eh);
    end
  endtask

  task automatic test_back_to_back;
    int n, eh;
    bit got;
    req_addr = 16'h1000;
    req = 1'b1;
    wait_ack(n);
    req_addr = 16'h1001;
    wait_ack(n);
    checks++;
    if (n != 4 || ADDR !== 16'h1001) begin
      errors++;
      $display("FAIL b2b_gap got %0d addr %h exp 4 1001", n, ADDR);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_with_ack got %b exp 1", done);
    end
    req = 1'b0;
    wait_done(eh, got);
  endtask

  task automatic test_vector;
    int n, eh;
    bit got;
    req_addr = 16'hFFFE;
    req_rnw = 1'b0;
    req_vec = 1'b1;
    resp_val = 8'h80;
    req = 1'b1;
    wait_ack(n);
    checks++;
    if (n < 0 || {BA, BS, RnW} !== 3'b011 || ADDR !== 16'hFFFE) begin
      errors++;
      $display("FAIL vector_bus got %b %h exp 011 fffe",
               {BA, BS, RnW}, ADDR);
    end
    req = 1'b0;
    req_vec = 1'b0;
    req_rnw = 1'b1;
    wait_done(eh, got);
    checks++;
    if (!got || rdata !== 8'h80) begin
      errors++;
      $display("FAIL vector_rdata got %h exp 80", rdata);
    end
  endtask

  task automatic test_idle;
    int bad;
    req = 1'b0;
    bad = 0;
    tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack || done || ADDR !== 16'hFFFF || !RnW || BS) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_cycle got %0d bad exp 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int n, seen;
    req_addr = 16'hFE30;
    req_wdata = 8'h77;
    req_rnw = 1'b0;
    req = 1'b1;
    wait_ack(n);
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (E && Q) break;
      tick();
    end
    probe_on = 1'b1;
    nRESET = 1'b0;
    tick();
    checks++;
    if ({E, Q, RnW, done} !== 4'b0010 || DATA !== 8'hA5) begin
      errors++;
      $display("FAIL reset_mid got %b data %h exp 0010 a5",
               {E, Q, RnW, done}, DATA);
    end
    seen = 0;
    tick();
    if (done) seen++;
    req_addr = 16'hFE20;
    req_rnw = 1'b1;
    req = 1'b1;
    nRESET = 1'b1;
    wait_ack(n);
    req = 1'b0;
    probe_on = 1'b0;
    checks++;
    if (n != 4 || seen != 0) begin
      errors++;
      $display("FAIL reset_release got ack at %0d done=%0d exp 4 0",
               n, seen);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stretch();
    test_timeout();
    test_nostretch();
    test_back_to_back();
    test_vector();
    test_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
